// File: rtl/max_bus_arbiter.sv
// ---------------------------------------------------------------------------
// max_bus_arbiter
//
// Purpose:
//   VIC/CPU bus arbiter. It divides the system clock into 8-CLK PHI cycles.
//   The first half of each PHI cycle belongs to the VIC and the second half
//   belongs to the CPU. When the VIC asks to steal the bus, BA drops for
//   BA_LEAD PHI cycles so the CPU can finish its current access. The VIC
//   then owns the bus (AEC low) for the latched number of PHI cycles.
//
// Parameters:
//   BA_LEAD    number of full PHI cycles BA is low before the steal (1..7)
//
// Ports:
//   i_clk      system clock, 8 CLK per PHI cycle
//   i_reset    synchronous active-high reset
//   i_vicReq   VIC bus-steal request, level sensitive
//   i_vicLen   number of PHI cycles to steal, latched with the request
//   o_phase    internal phase counter PH (0..7)
//   o_phi2     CPU phase clock, high while PH is 4..7
//   o_ba       bus available to CPU RDY, low while a burst is pending/active
//   o_aec      CPU address enable, low while the VIC owns the bus
//   o_cpuCe    one-CLK CPU clock enable at PH=7 when the CPU is not stalled
//   o_vicSlot  one-CLK strobe at PH=4 of every stolen PHI cycle
//   o_done     one-CLK strobe at PH=0 of the first IDLE cycle after a steal
// ---------------------------------------------------------------------------
module max_bus_arbiter #(
    parameter int BA_LEAD = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_vicReq,
    input  logic [5:0] i_vicLen,
    output logic [2:0] o_phase,
    output logic       o_phi2,
    output logic       o_ba,
    output logic       o_aec,
    output logic       o_cpuCe,
    output logic       o_vicSlot,
    output logic       o_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BA_WAIT = 2'd1,
        STEAL   = 2'd2
    } ArbState;

    localparam logic [2:0] LEAD_INIT = 3'(BA_LEAD);

    ArbState    r_state;
    ArbState    w_nextState;
    logic [2:0] r_ph;
    logic [2:0] r_leadCnt;
    logic [5:0] r_lenCnt;
    logic       r_done;
    logic       w_wrap;
    logic       w_accept;

    // The wrap edge is the clock edge that ends PH=7. State changes and
    // request sampling happen only on this edge. A request with a zero
    // length is never accepted, so it cannot disturb the CPU cadence.
    assign w_wrap   = (r_ph == 3'd7);
    assign w_accept = w_wrap && (r_state == IDLE) && i_vicReq && (i_vicLen != 6'd0);

    // State register and phase counter. The phase counter runs freely and
    // wraps on its own. DONE is registered on the STEAL->IDLE wrap edge, so
    // it lines up with PH=0 of the first IDLE cycle. A reset clears DONE,
    // so an aborted burst never produces the strobe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ph    <= 3'd0;
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_ph    <= r_ph + 3'd1;
            r_state <= w_nextState;
            r_done  <= w_wrap && (r_state == STEAL) && (w_nextState == IDLE);
        end
    end

    // Lead and length counters. They load when a request is accepted and
    // count down once per PHI cycle in their own state. They stop at zero
    // rather than wrapping, so a stale counter can never restart a burst.
    // The length is latched here, which means later changes on i_vicLen
    // have no effect on a burst that is already running.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_leadCnt <= 3'd0;
            r_lenCnt  <= 6'd0;
        end else if (w_accept) begin
            r_leadCnt <= LEAD_INIT;
            r_lenCnt  <= i_vicLen;
        end else if (w_wrap) begin
            if (r_state == BA_WAIT && r_leadCnt != 3'd0) begin
                r_leadCnt <= r_leadCnt - 3'd1;
            end
            if (r_state == STEAL && r_lenCnt != 6'd0) begin
                r_lenCnt <= r_lenCnt - 6'd1;
            end
        end
    end

    // Next-state logic. Each waiting state leaves on the wrap edge that ends
    // its last PHI cycle, which is when its counter still reads 1. The test
    // is "<= 1" so a counter that is already at zero also moves the FSM on
    // instead of stalling it.
    always_comb begin
        w_nextState = r_state;
        if (w_wrap) begin
            case (r_state)
                IDLE:    if (w_accept)             w_nextState = BA_WAIT;
                BA_WAIT: if (r_leadCnt <= 3'd1)    w_nextState = STEAL;
                STEAL:   if (r_lenCnt <= 6'd1)     w_nextState = IDLE;
                default:                           w_nextState = IDLE;
            endcase
        end
    end

    // Output decode from the current state and phase. The CPU gets its
    // clock enable in IDLE and BA_WAIT so it can finish the access it has
    // in flight. It is fully stalled while the VIC owns the bus.
    always_comb begin
        o_phase   = r_ph;
        o_phi2    = r_ph[2];
        o_ba      = (r_state == IDLE);
        o_aec     = (r_state != STEAL);
        o_cpuCe   = (r_ph == 3'd7) && (r_state != STEAL);
        o_vicSlot = (r_ph == 3'd4) && (r_state == STEAL);
        o_done    = r_done;
    end

endmodule

// File: doc/max_bus_arbiter.md
MAX_BUS_ARBITER -- requirements
Module: max_bus_arbiter

Interface
REQ-001 The block SHALL have parameter BA_LEAD, default 3, meaning the number of full PHI cycles BA is low before the bus is stolen (legal 1..7).
REQ-002 The block SHALL have port CLK  input  1  system clock, 8 CLK cycles per PHI cycle.
REQ-003 The block SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port VIC_REQ  input  1  VIC bus-steal request (badline/sprite DMA), level.
REQ-005 The block SHALL have port VIC_LEN  input  6  number of PHI cycles to steal, latched with the request.
REQ-006 The block SHALL have port PHASE  output  3  internal phase counter PH.
REQ-007 The block SHALL have port PHI2  output  1  CPU phase clock.
REQ-008 The block SHALL have port BA  output  1  bus available to CPU RDY, active-high.
REQ-009 The block SHALL have port AEC  output  1  CPU address enable, low = VIC owns the bus.
REQ-010 The block SHALL have port CPU_CE  output  1  one-CLK CPU clock enable strobe.
REQ-011 The block SHALL have port VIC_SLOT  output  1  one-CLK strobe marking each stolen PHI2 slot.
REQ-012 The block SHALL have port DONE  output  1  one-CLK strobe marking the end of a steal burst.

Function
REQ-013 PH SHALL increment by 1 every CLK and wrap 7->0; a PHI cycle is PH=0..7; PH=0..3 is PHI1 (VIC half), PH=4..7 is PHI2 (CPU half).
REQ-014 PHI2 SHALL be 1 exactly when PH is in 4..7.
REQ-015 The FSM SHALL have states IDLE, BA_WAIT, STEAL; state changes occur only on the CLK edge where PH wraps 7->0 (the "wrap edge").
REQ-016 In IDLE at a wrap edge, if VIC_REQ=1 and VIC_LEN!=0, the FSM SHALL latch VIC_LEN, load the lead counter with BA_LEAD, and enter BA_WAIT.
REQ-017 In IDLE, VIC_REQ=1 with VIC_LEN=0 SHALL be ignored: the FSM stays in IDLE and no output changes.
REQ-018 VIC_REQ and VIC_LEN SHALL be sampled only at wrap edges in IDLE; changes at other times or in other states have no effect.
REQ-019 BA_WAIT SHALL last exactly BA_LEAD PHI cycles, then enter STEAL.
REQ-020 STEAL SHALL last exactly the latched VIC_LEN PHI cycles, then enter IDLE.
REQ-021 BA SHALL be 0 in BA_WAIT and STEAL, and 1 in IDLE.
REQ-022 AEC SHALL be 0 in STEAL and 1 otherwise.
REQ-023 CPU_CE SHALL be 1 for the CLK where PH=7 in IDLE or BA_WAIT, and 0 at all other times, including every cycle in STEAL.
REQ-024 VIC_SLOT SHALL be 1 for the CLK where PH=4 in STEAL, and 0 otherwise.
REQ-025 DONE SHALL be 1 for the CLK at PH=0 of the first IDLE cycle after STEAL, and 0 otherwise.
REQ-026 Back-to-back bursts: a request held through a burst SHALL NOT be sampled until the first IDLE wrap edge, giving at least one full IDLE PHI cycle (BA=1, one CPU_CE) between bursts.
REQ-027 Latched length and lead counters SHALL count down to zero without wrapping; the maximum burst is 63 stolen cycles.

Reset
REQ-028 With RESET=1 at a CLK edge, the block SHALL set PH=0 and the FSM to IDLE, and clear the latched length and lead counter.
REQ-029 During and after reset, outputs SHALL be PHI2=0, BA=1, AEC=1, CPU_CE=0, VIC_SLOT=0, DONE=0.
REQ-030 Reset asserted during BA_WAIT or STEAL SHALL abort the burst immediately: BA and AEC go to 1 and no DONE pulse is produced.

Verification
REQ-031 Free run after reset, VIC_REQ=0 -> PHI2 is a 4-high/4-low square wave; CPU_CE pulses every 8 CLK at PH=7; BA=AEC=1 throughout.
REQ-032 VIC_REQ=1, VIC_LEN=2 at the wrap edge -> BA=0 for 40 CLK; AEC=0 for the last 16 CLK; 3 CPU_CE pulses then none for 2 PHI cycles; 2 VIC_SLOT pulses; DONE pulses at the first CLK after BA returns to 1.
REQ-033 VIC_REQ=1, VIC_LEN=0 -> BA, AEC and CPU_CE cadence unchanged; no DONE pulse.
REQ-034 VIC_REQ held at 1 with VIC_LEN=40 -> 43-cycle BA-low bursts separated by exactly 1 IDLE PHI cycle containing one CPU_CE pulse; 40 VIC_SLOT pulses per burst.
REQ-035 RESET pulsed at PH=5 of the 10th STEAL cycle -> the next CLK shows PH=0, BA=1, AEC=1, no DONE pulse; a subsequent request runs a normal burst.
REQ-036 VIC_LEN changed mid-burst from 2 to 9 -> the burst length stays 2.
